mouse_tracker: RTL and testbench



---
 rtl/mouse_pkg.sv | 28 ++
 rtl/axis_accum.sv | 32 +++
 rtl/mouse_tracker.sv | 149 ++++++++++++++
 tb/tb_mouse_tracker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker: packet FSM states,
// status-byte bit positions and the PS/2 controller reply codes.
package mouse_pkg;

   typedef enum logic [1:0] {
      WAIT_B0,
      WAIT_B1,
      WAIT_B2,
      APPLY
   } stateT;

   localparam int BIT_L       = 0;
   localparam int BIT_R       = 1;
   localparam int BIT_ALWAYS1 = 3;
   localparam int BIT_XS      = 4;
   localparam int BIT_YS      = 5;
   localparam int BIT_XO      = 6;
   localparam int BIT_YO      = 7;

   localparam logic [7:0] PS2_ACK = 8'hFA;
   localparam logic [7:0] PS2_BAT = 8'hAA;

   // ACK and BAT both have bit 3 set, so they must be rejected explicitly.
   function automatic logic isStatusByte(input logic [7:0] b);
      return b[BIT_ALWAYS1] && (b != PS2_ACK) && (b != PS2_BAT);
   endfunction

endpackage

// File: rtl/axis_accum.sv
// Combinational cursor axis update: position plus or minus a 9-bit signed
// delta, evaluated at 11-bit signed width and clamped to [0, LIMIT-1].
module axis_accum #(
   parameter int LIMIT = 320,
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0]  pos,
   input  logic signed [8:0] delta,
   input  logic              subtract,
   output logic [WIDTH-1:0]  newPos
);

   localparam logic signed [10:0] MAXV = 11'(LIMIT - 1);

   logic signed [10:0] posExt;
   logic signed [10:0] deltaExt;
   logic signed [10:0] sum;

   always_comb begin
      posExt   = $signed({{(11 - WIDTH){1'b0}}, pos});
      deltaExt = $signed({{2{delta[8]}}, delta});
      sum      = subtract ? (posExt - deltaExt) : (posExt + deltaExt);
      if (sum < 11'sd0) begin
         newPos = '0;
      end else if (sum > MAXV) begin
         newPos = MAXV[WIDTH-1:0];
      end else begin
         newPos = sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and turns them into a clamped cursor
// position, button levels and one-cycle click / packet-applied pulses.
module mouse_tracker
   import mouse_pkg::*;
#(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int TIMEOUT  = 2_000_000
) (
   input  logic       clk,
   input  logic       iResetn,
   input  logic [7:0] iData,
   input  logic       iDataEn,
   output logic [8:0] oMouseX,
   output logic [7:0] oMouseY,
   output logic       oLeftHeld,
   output logic       oRightHeld,
   output logic       oLeftClick,
   output logic       oRightClick,
   output logic       oPacketValid
);

   localparam int         CW       = $clog2(TIMEOUT + 1);
   localparam logic [8:0] CENTER_X = 9'(SCREEN_W / 2);
   localparam logic [7:0] CENTER_Y = 8'(SCREEN_H / 2);

   stateT   state;
   stateT   nextState;
   logic [CW-1:0] idleCount;
   logic    timeoutHit;
   logic    captureStatus;
   logic    captureDx;
   logic    captureDy;

   logic       btnL, btnR, signX, signY, ovfX, ovfY;
   logic [7:0] dxReg;
   logic [7:0] dyReg;

   logic signed [8:0] deltaX;
   logic signed [8:0] deltaY;
   logic [8:0] nextX;
   logic [7:0] nextY;

   assign timeoutHit = ((state == WAIT_B1) || (state == WAIT_B2)) &&
                       (idleCount == CW'(TIMEOUT));

   // APPLY and an expired timeout both fall back to status-byte hunting,
   // so a byte arriving in those cycles is judged as a packet start.
   always_comb begin
      nextState     = state;
      captureStatus = 1'b0;
      captureDx     = 1'b0;
      captureDy     = 1'b0;
      if ((state == WAIT_B0) || (state == APPLY) || timeoutHit) begin
         nextState = WAIT_B0;
         if (iDataEn && isStatusByte(iData)) begin
            captureStatus = 1'b1;
            nextState     = WAIT_B1;
         end
      end else if (iDataEn) begin
         if (state == WAIT_B1) begin
            captureDx = 1'b1;
            nextState = WAIT_B2;
         end else begin
            captureDy = 1'b1;
            nextState = APPLY;
         end
      end
   end

   always_ff @(posedge clk or negedge iResetn) begin
      if (!iResetn) begin
         state     <= WAIT_B0;
         idleCount <= '0;
      end else begin
         state <= nextState;
         if (((state == WAIT_B1) || (state == WAIT_B2)) && !iDataEn && !timeoutHit) begin
            idleCount <= idleCount + CW'(1);
         end else begin
            idleCount <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge iResetn) begin
      if (!iResetn) begin
         btnL  <= 1'b0;
         btnR  <= 1'b0;
         signX <= 1'b0;
         signY <= 1'b0;
         ovfX  <= 1'b0;
         ovfY  <= 1'b0;
         dxReg <= '0;
         dyReg <= '0;
      end else begin
         if (captureStatus) begin
            btnL  <= iData[BIT_L];
            btnR  <= iData[BIT_R];
            signX <= iData[BIT_XS];
            signY <= iData[BIT_YS];
            ovfX  <= iData[BIT_XO];
            ovfY  <= iData[BIT_YO];
         end
         if (captureDx) begin
            dxReg <= iData;
         end
         if (captureDy) begin
            dyReg <= iData;
         end
      end
   end

   assign deltaX = ovfX ? 9'sd0 : $signed({signX, dxReg});
   assign deltaY = ovfY ? 9'sd0 : $signed({signY, dyReg});

   axis_accum #(.LIMIT(SCREEN_W), .WIDTH(9)) xAxis (
      .pos      (oMouseX),
      .delta    (deltaX),
      .subtract (1'b0),
      .newPos   (nextX)
   );

   // PS/2 reports Y as up-positive while screen rows grow downward.
   axis_accum #(.LIMIT(SCREEN_H), .WIDTH(8)) yAxis (
      .pos      (oMouseY),
      .delta    (deltaY),
      .subtract (1'b1),
      .newPos   (nextY)
   );

   always_ff @(posedge clk or negedge iResetn) begin
      if (!iResetn) begin
         oMouseX    <= CENTER_X;
         oMouseY    <= CENTER_Y;
         oLeftHeld  <= 1'b0;
         oRightHeld <= 1'b0;
      end else if (state == APPLY) begin
         oMouseX    <= nextX;
         oMouseY    <= nextY;
         oLeftHeld  <= btnL;
         oRightHeld <= btnR;
      end
   end

   assign oPacketValid = (state == APPLY);
   assign oLeftClick   = (state == APPLY) && btnL && !oLeftHeld;
   assign oRightClick  = (state == APPLY) && btnR && !oRightHeld;

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed-vector bench for mouse_tracker: feeds PS/2 byte streams and
// compares position, buttons and pulses against hand-computed values.
module tb_mouse_tracker;

   localparam int TOUT = 16;

   logic       clk;
   logic       iResetn;
   logic [7:0] iData;
   logic       iDataEn;
   logic [8:0] oMouseX;
   logic [7:0] oMouseY;
   logic       oLeftHeld, oRightHeld, oLeftClick, oRightClick, oPacketValid;

   int vectors     = 0;
   int miscompares = 0;

   logic seenValid, seenLeftClick, seenRightClick, validAfter;

   mouse_tracker #(.SCREEN_W(320), .SCREEN_H(240), .TIMEOUT(TOUT)) dut (
      .clk          (clk),
      .iResetn      (iResetn),
      .iData        (iData),
      .iDataEn      (iDataEn),
      .oMouseX      (oMouseX),
      .oMouseY      (oMouseY),
      .oLeftHeld    (oLeftHeld),
      .oRightHeld   (oRightHeld),
      .oLeftClick   (oLeftClick),
      .oRightClick  (oRightClick),
      .oPacketValid (oPacketValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic driveByte(input logic [7:0] b);
      iData   = b;
      iDataEn = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      iDataEn = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Sends a whole packet, samples the pulses during APPLY, then lets the
   // registered outputs settle one cycle later.
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      driveByte(b0);
      driveByte(b1);
      driveByte(b2);
      iDataEn        = 1'b0;
      seenValid      = oPacketValid;
      seenLeftClick  = oLeftClick;
      seenRightClick = oRightClick;
      @(negedge clk);
      validAfter = oPacketValid;
   endtask

   task automatic doReset();
      @(negedge clk);
      iDataEn = 1'b0;
      iResetn = 1'b0;
      #1;
      checkOutput("rstX", int'(oMouseX), 160);
      checkOutput("rstY", int'(oMouseY), 120);
      checkOutput("rstHeld", int'({oLeftHeld, oRightHeld}), 0);
      checkOutput("rstPulses", int'({oLeftClick, oRightClick, oPacketValid}), 0);
      @(negedge clk);
      iResetn = 1'b1;
   endtask

   initial begin
      iResetn = 1'b1;
      iData   = 8'h00;
      iDataEn = 1'b0;

      // Basic move with both signs positive
      doReset();
      applyStimulus(8'h08, 8'h05, 8'h03);
      checkOutput("basicValid", int'(seenValid), 1);
      checkOutput("basicValidOnce", int'(validAfter), 0);
      checkOutput("basicClicks", int'({seenLeftClick, seenRightClick}), 0);
      checkOutput("basicX", int'(oMouseX), 165);
      checkOutput("basicY", int'(oMouseY), 117);

      // Async reset while off-centre
      doReset();
      applyStimulus(8'h18, 8'hF6, 8'h00);
      checkOutput("negDxX", int'(oMouseX), 150);
      checkOutput("negDxY", int'(oMouseY), 120);

      // Y bottom clamp, X right clamp
      doReset();
      applyStimulus(8'h28, 8'h00, 8'h80);
      checkOutput("yClamp1", int'(oMouseY), 239);
      applyStimulus(8'h28, 8'h00, 8'h80);
      checkOutput("yClamp2", int'(oMouseY), 239);
      for (int i = 0; i < 4; i++) applyStimulus(8'h08, 8'hC8, 8'h00);
      checkOutput("xClampHi", int'(oMouseX), 319);

      // X left clamp, Y top clamp
      doReset();
      applyStimulus(8'h18, 8'h80, 8'h00);
      checkOutput("xStep", int'(oMouseX), 32);
      applyStimulus(8'h18, 8'h80, 8'h00);
      checkOutput("xClampLo", int'(oMouseX), 0);
      applyStimulus(8'h08, 8'h00, 8'h7F);
      checkOutput("yClampLo", int'(oMouseY), 0);

      // ACK dropped, left click edge detection
      doReset();
      driveByte(8'hFA);
      applyStimulus(8'h09, 8'h00, 8'h00);
      checkOutput("ackValid", int'(seenValid), 1);
      checkOutput("leftClick1", int'(seenLeftClick), 1);
      checkOutput("leftHeld1", int'(oLeftHeld), 1);
      applyStimulus(8'h09, 8'h00, 8'h00);
      checkOutput("leftClick2", int'(seenLeftClick), 0);
      checkOutput("leftHeld2", int'(oLeftHeld), 1);
      applyStimulus(8'h08, 8'h00, 8'h00);
      checkOutput("leftClick3", int'(seenLeftClick), 0);
      checkOutput("leftHeld3", int'(oLeftHeld), 0);
      checkOutput("ackPos", int'({7'd0, oMouseX, oMouseY}), (160 << 8) | 120);

      // Right button, and BAT / bit3=0 bytes ignored
      doReset();
      driveByte(8'h00);
      driveByte(8'hAA);
      applyStimulus(8'h0A, 8'h02, 8'h00);
      checkOutput("rightClick", int'(seenRightClick), 1);
      checkOutput("rightNoLeft", int'(seenLeftClick), 0);
      checkOutput("rightHeld", int'(oRightHeld), 1);
      checkOutput("batX", int'(oMouseX), 162);

      // Partial packet abandoned; byte at the expiry cycle starts a packet
      doReset();
      driveByte(8'h08);
      driveByte(8'h10);
      idle(TOUT);
      applyStimulus(8'h08, 8'h01, 8'h01);
      checkOutput("toutX", int'(oMouseX), 161);
      checkOutput("toutY", int'(oMouseY), 119);

      // Reset mid-packet, then X overflow ignores dx
      doReset();
      applyStimulus(8'h08, 8'h03, 8'h00);
      driveByte(8'h08);
      driveByte(8'h7F);
      doReset();
      checkOutput("midRstX", int'(oMouseX), 160);
      applyStimulus(8'h48, 8'hFF, 8'h02);
      checkOutput("ovfValid", int'(seenValid), 1);
      checkOutput("ovfX", int'(oMouseX), 160);
      checkOutput("ovfY", int'(oMouseY), 118);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
